lsu_seq: RTL and testbench

Load/store sequencer that sits between the core's memory stage and the data memory. It accepts one load or store request at a time over a valid/ready handshake and drives the data memory port (MemWrite, SizeLoad, a, wd). It captures read data and returns a registered response. Sub-word sign and zero extension happen here. Misaligned halfword and word accesses are split into byte beats.

---
 rtl/lsu_seq.sv | 194 +++++++++++++++++++
 tb/tb_lsu_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_seq.sv
// lsu_seq: load/store sequencer between the core memory stage and data memory.
//
// Takes one load or store at a time over req_valid/req_ready, drives the data
// memory port for one access cycle (or one cycle per byte beat for a split
// misaligned access), captures mem_rd and returns a registered response with
// sub-word sign/zero extension applied.
//
// Optional feature macro: LSU_MISALIGN_SPLIT_EN
//   defined   - misaligned H/HU/W accesses are split into byte beats
//   undefined - misaligned H/HU/W accesses are answered with resp_err
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake
//   req_we, req_funct3           store flag, RISC-V funct3 access size
//   req_addr, req_wdata          byte address, store data
//   resp_valid, resp_err         one-cycle response pulse, error flag
//   resp_rdata                   extended load data, held until next response
//   mem_MemWrite, mem_SizeLoad   memory write size / load size codes
//   mem_a, mem_wd, mem_rd        memory address, write data, read data
module lsu_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [1:0]  mem_MemWrite,
  output logic [2:0]  mem_SizeLoad,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        err_reg;
  logic [31:0] rdata_reg;

  logic        accept;
  logic        req_illegal;
  logic        req_misaligned;
  logic        req_err;
  logic        last_beat;
  logic [31:0] load_word;

  // Sign extension for B/H, zero extension for BU/HU, word passes through.
  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Nothing may be accepted while reset is held, so ready is masked by reset_n
  // as well as by the state.
  assign req_ready = reset_n && ((state_reg == IDLE) || (state_reg == RESP));
  assign accept    = req_valid && req_ready;

  // 011 and 11x are not load/store sizes; unsigned sizes make no sense for stores.
  assign req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                       (req_we && req_funct3[2]);
  assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [1:0]  beat_reg;     // index of the beat in flight
  logic [1:0]  last_reg;     // index of the final beat (0 for aligned)
  logic [31:0] asm_reg;      // load bytes gathered from earlier beats
  logic [31:0] asm_cur;      // asm_reg with the current beat's byte merged in
  logic [1:0]  req_last;
  logic        split_access;

  assign req_err      = req_illegal;
  assign req_last     = !req_misaligned ? 2'd0 : (req_funct3[1] ? 2'd3 : 2'd1);
  assign split_access = (last_reg != 2'd0);
  assign last_beat    = (beat_reg == last_reg);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign asm_cur[8*gi +: 8] = (beat_reg == 2'(gi)) ? mem_rd[7:0] : asm_reg[8*gi +: 8];
  end

  assign load_word = split_access ? asm_cur : mem_rd;
`else
  assign req_err   = req_illegal || req_misaligned;
  assign last_beat = 1'b1;
  assign load_word = mem_rd;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    mem_MemWrite = 2'b00;
    mem_SizeLoad = 3'b111;
    mem_a        = 32'd0;
    mem_wd       = 32'd0;
    case (state_reg)
      IDLE, RESP: begin
        if (accept) state_next = req_err ? RESP : ACCESS;
        else        state_next = IDLE;
      end
      ACCESS: begin
        if (last_beat) state_next = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (split_access) begin
          mem_a = addr_reg + {30'd0, beat_reg};
          if (we_reg) begin
            mem_MemWrite = 2'b11;
            mem_wd       = {24'd0, wdata_reg[{beat_reg, 3'b000} +: 8]};
          end else begin
            mem_SizeLoad = 3'b011;
          end
        end else
`endif
        begin
          mem_a = addr_reg;
          if (we_reg) begin
            mem_wd = wdata_reg;
            case (funct3_reg[1:0])
              2'b00:   mem_MemWrite = 2'b11;
              2'b01:   mem_MemWrite = 2'b10;
              default: mem_MemWrite = 2'b01;
            endcase
          end else begin
            // Only unsigned sub-word codes are issued; extension is done here.
            case (funct3_reg[1:0])
              2'b00:   mem_SizeLoad = 3'b011;
              2'b01:   mem_SizeLoad = 3'b101;
              default: mem_SizeLoad = 3'b000;
            endcase
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_reg     <= 1'b0;
      funct3_reg <= 3'd0;
      addr_reg   <= 32'd0;
      wdata_reg  <= 32'd0;
      err_reg    <= 1'b0;
      rdata_reg  <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      beat_reg   <= 2'd0;
      last_reg   <= 2'd0;
      asm_reg    <= 32'd0;
`endif
    end else if (accept) begin
      we_reg     <= req_we;
      funct3_reg <= req_funct3;
      addr_reg   <= req_addr;
      wdata_reg  <= req_wdata;
      err_reg    <= req_err;
      // An error response is produced right away, so its data is set here.
      if (req_err) rdata_reg <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      beat_reg   <= 2'd0;
      last_reg   <= req_err ? 2'd0 : req_last;
      asm_reg    <= 32'd0;
`endif
    end else if (state_reg == ACCESS) begin
`ifdef LSU_MISALIGN_SPLIT_EN
      beat_reg <= beat_reg + 2'd1;
      asm_reg  <= asm_cur;
`endif
      if (last_beat) rdata_reg <= we_reg ? 32'd0 : extend(funct3_reg, load_word);
    end
  end

  assign resp_valid = (state_reg == RESP);
  assign resp_err   = err_reg;
  assign resp_rdata = rdata_reg;

endmodule

// File: tb/tb_lsu_seq.sv
module tb_lsu_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  mem_MemWrite;
  logic [2:0]  mem_SizeLoad;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd = 32'd0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;       // number of rising edges seen so far
  int acc_cnt = 0;   // memory-active cycles since the last response

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          n;      // beats expected
    logic        err;
    logic [31:0] rdata;
    int          rcyc;   // value of cyc during the response cycle
  } exp_t;

  exp_t sb_q[$];

  logic [7:0] phys_mem [logic [31:0]];  // memory as the DUT writes it
  logic [7:0] ref_mem  [logic [31:0]];  // memory as the reference model expects

  lsu_seq dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_MemWrite(mem_MemWrite), .mem_SizeLoad(mem_SizeLoad),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pb(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : 8'h00;
  endfunction

  function automatic logic [7:0] rb(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model plus monitor, all on the falling edge where DUT outputs are stable.
  always @(negedge clk) begin
    logic [31:0] r;
    logic [31:0] ea;
    int          i;
    int          nb;
    exp_t        e;
    if (reset_n && mem_MemWrite != 2'b00) begin
      nb = (mem_MemWrite == 2'b11) ? 1 : (mem_MemWrite == 2'b10) ? 2 : 4;
      for (int k = 0; k < nb; k++) phys_mem[mem_a + 32'(k)] = mem_wd[8*k +: 8];
    end
    // Upper bits are random for sub-word reads: the LSU must ignore them.
    r = $urandom();
    case (mem_SizeLoad)
      3'b011:  mem_rd = {r[31:8], pb(mem_a)};
      3'b101:  mem_rd = {r[31:16], pb(mem_a + 32'd1), pb(mem_a)};
      3'b000:  mem_rd = {pb(mem_a + 32'd3), pb(mem_a + 32'd2), pb(mem_a + 32'd1), pb(mem_a)};
      default: mem_rd = r;
    endcase

    if (reset_n && (mem_MemWrite != 2'b00 || mem_SizeLoad != 3'b111)) begin
      if (sb_q.size() == 0 || sb_q[0].err) begin
        checks++;
        errors++;
        $display("FAIL spurious_access: got MemWrite=%b SizeLoad=%b expected no access", mem_MemWrite, mem_SizeLoad);
      end else begin
        i  = acc_cnt;
        ea = (sb_q[0].n > 1) ? sb_q[0].addr + 32'(i) : sb_q[0].addr;
        chk("mem_a", mem_a, ea);
        if (sb_q[0].we) begin
          if (sb_q[0].n > 1) begin
            chk("mem_MemWrite", {30'd0, mem_MemWrite}, 32'd3);
            chk("mem_wd", mem_wd, {24'd0, sb_q[0].wdata[8*(i%4) +: 8]});
          end else begin
            case (sb_q[0].f3[1:0])
              2'b00:   chk("mem_MemWrite", {30'd0, mem_MemWrite}, 32'd3);
              2'b01:   chk("mem_MemWrite", {30'd0, mem_MemWrite}, 32'd2);
              default: chk("mem_MemWrite", {30'd0, mem_MemWrite}, 32'd1);
            endcase
            chk("mem_wd", mem_wd, sb_q[0].wdata);
          end
        end else begin
          chk("mem_MemWrite", {30'd0, mem_MemWrite}, 32'd0);
          chk("mem_wd", mem_wd, 32'd0);
          if (sb_q[0].n > 1) chk("mem_SizeLoad", {29'd0, mem_SizeLoad}, 32'd3);
          else case (sb_q[0].f3[1:0])
            2'b00:   chk("mem_SizeLoad", {29'd0, mem_SizeLoad}, 32'd3);
            2'b01:   chk("mem_SizeLoad", {29'd0, mem_SizeLoad}, 32'd5);
            default: chk("mem_SizeLoad", {29'd0, mem_SizeLoad}, 32'd0);
          endcase
        end
      end
      acc_cnt = acc_cnt + 1;
    end

    if (reset_n && resp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cyc %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_cycle", cyc, e.rcyc);
        chk("access_beats", acc_cnt, e.err ? 0 : e.n);
        $display("resp we=%0d f3=%b addr=%h wdata=%h -> err=%0d rdata=%h",
                 e.we, e.f3, e.addr, e.wdata, resp_err, resp_rdata);
      end
      acc_cnt = 0;
    end
  end

  // Issue one request; the reference model is updated at issue time.
  // commit limits how many store bytes reach memory (used for the reset case).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int commit = -1);
    exp_t        e;
    logic        illegal;
    logic        mis;
    logic [31:0] w;
    int          sz;
    int          waited;
    bit          ok;
    sz      = size_of(f3);
    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
              (we && (f3 == 3'b100 || f3 == 3'b101));
    mis     = (addr % sz) != 0;
    e.we = we; e.f3 = f3; e.addr = addr; e.wdata = wdata;
    e.err   = illegal || (mis && !SPLIT);
    e.n     = (mis && !e.err) ? sz : 1;
    e.rdata = 32'd0;
    e.rcyc  = 0;
    if (!e.err) begin
      if (we) begin
        for (int i = 0; i < sz; i++)
          if (commit < 0 || i < commit) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
      end else begin
        w = 32'd0;
        for (int i = 0; i < sz; i++) w[8*i +: 8] = rb(addr + 32'(i));
        case (f3)
          3'b000:  e.rdata = {{24{w[7]}}, w[7:0]};
          3'b001:  e.rdata = {{16{w[15]}}, w[15:0]};
          3'b100:  e.rdata = {24'd0, w[7:0]};
          3'b101:  e.rdata = {16'd0, w[15:0]};
          default: e.rdata = w;
        endcase
      end
    end
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    waited = 0;
    ok = 0;
    while (waited < 100 && !ok) begin
      @(negedge clk);
      if (req_ready) ok = 1;
      else waited++;
    end
    checks++;
    if (ok) begin
      e.rcyc = cyc + 1 + (e.err ? 0 : e.n);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
    end else begin
      errors++;
      $display("FAIL req_ready_timeout: got ready=0 for 100 cycles expected acceptance");
    end
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb_q.size() != 0 && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_MemWrite"}, {30'd0, mem_MemWrite}, 32'd0);
    chk({tag, "_SizeLoad"}, {29'd0, mem_SizeLoad}, 32'd7);
    chk({tag, "_mem_a"}, mem_a, 32'd0);
    chk({tag, "_mem_wd"}, mem_wd, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  f3;
    #2;
    chk_idle_outputs("reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Word store/load round trip.
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    // Byte store, signed and unsigned byte load.
    issue(1'b1, 3'b000, 32'h13, 32'h00000080);
    issue(1'b0, 3'b000, 32'h13, 32'h0);
    issue(1'b0, 3'b100, 32'h13, 32'h0);
    issue(1'b0, 3'b001, 32'h12, 32'h0);
    issue(1'b0, 3'b101, 32'h12, 32'h0);
    drain();

    // Misaligned word store on zeroed memory, then readback.
    phys_mem.delete();
    ref_mem.delete();
    issue(1'b1, 3'b010, 32'h21, 32'h11223344);
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    issue(1'b0, 3'b010, 32'h24, 32'h0);
    issue(1'b0, 3'b001, 32'h23, 32'h0);
    issue(1'b0, 3'b101, 32'h21, 32'h0);
    // Wrap-around at the top of the address space.
    issue(1'b1, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4);
    issue(1'b0, 3'b100, 32'hFFFFFFFF, 32'h0);
    issue(1'b0, 3'b000, 32'h00000000, 32'h0);
    issue(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);

    // Illegal requests back to back; each next request is accepted during RESP.
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    issue(1'b1, 3'b101, 32'h10, 32'h5555AAAA);
    issue(1'b1, 3'b111, 32'h10, 32'h5555AAAA);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    drain();

    // Reset in the middle of a store.
    phys_mem.delete();
    ref_mem.delete();
    if (SPLIT) begin
      issue(1'b1, 3'b010, 32'h21, 32'h11223344, 2);
      repeat (2) @(posedge clk);
      #1;
    end else begin
      issue(1'b1, 3'b010, 32'h40, 32'hCAFEF00D, 0);
    end
    reset_n = 1'b0;
    sb_q.delete();
    acc_cnt = 0;
    #1;
    chk_idle_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    issue(1'b0, 3'b010, 32'h24, 32'h0);
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    drain();

    // Randomized traffic in two small windows, one straddling the wrap point.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      a  = ($urandom_range(0, 1) == 0 ? 32'h00000100 : 32'hFFFFFFF8) + 32'($urandom_range(0, 15));
      f3 = 3'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 1)), f3, a, $urandom());
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion within 50000 cycles");
    $fatal(1);
  end

endmodule
